// File: rtl/ga_serial_job_master_if.sv
// Job/result signals between the GA serial job master and its host-side user.
// The master modport is the job master itself; slave is the driving environment.
interface ga_serial_job_master_if;
  logic        start;
  logic [31:0] origin;
  logic [31:0] objetive;
  logic        tx;
  logic        rx;
  logic        busy;
  logic        resultValid;
  logic [15:0] resultError;
  logic [15:0] resultCounter;
  logic [31:0] resultIndividual;
  logic        timeout;

  modport master (
    input  start, origin, objetive, rx,
    output tx, busy, resultValid, resultError, resultCounter, resultIndividual, timeout
  );

  modport slave (
    output start, origin, objetive, rx,
    input  tx, busy, resultValid, resultError, resultCounter, resultIndividual, timeout
  );
endinterface

// File: rtl/ga_serial_job_master.sv
// Host-side peer of the GA debug link: sends a 64-bit job as 8 UART bytes (8N1, MSB byte first)
// and collects the 8-byte result packet, aborting on framing error or inter-byte timeout.
module ga_serial_job_master #(
  parameter int unsigned ClkPerBit     = 16,
  parameter int unsigned TimeoutCycles = 65535,
  parameter int unsigned TimeoutWidth  = 16
) (
  input logic                    clk,
  input logic                    rst,
  ga_serial_job_master_if.master bus
);
  localparam int unsigned CntW = $clog2(ClkPerBit);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClkPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(ClkPerBit / 2 - 1);
  localparam logic [TimeoutWidth-1:0] TimeLast = TimeoutWidth'(TimeoutCycles - 1);

  typedef enum logic [2:0] {StIdle, StSend, StRecv, StDone, StAbort} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             job_q, job_d;
  logic [CntW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]              tx_bit_q, tx_bit_d;
  logic [2:0]              tx_byte_q, tx_byte_d;
  logic                    rx_s1_q, rx_s2_q, rx_s3_q;
  logic                    rx_active_q, rx_active_d;
  logic [CntW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [3:0]              rx_bit_q, rx_bit_d;
  logic [7:0]              rx_byte_q, rx_byte_d;
  logic [2:0]              rx_nbytes_q, rx_nbytes_d;
  logic [55:0]             res_sr_q, res_sr_d;
  logic [TimeoutWidth-1:0] tcnt_q, tcnt_d;
  logic [63:0]             result_q, result_d;
  logic                    tx_line;
  logic                    rx_fall;
  logic [3:0]              tx_di;
  logic [7:0]              tx_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      job_q       <= '0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_byte_q   <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_byte_q   <= '0;
      rx_nbytes_q <= '0;
      res_sr_q    <= '0;
      tcnt_q      <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      rx_s1_q     <= bus.rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_active_q <= rx_active_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_byte_q   <= rx_byte_d;
      rx_nbytes_q <= rx_nbytes_d;
      res_sr_q    <= res_sr_d;
      tcnt_q      <= tcnt_d;
      result_q    <= result_d;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign tx_cur  = job_q[63:56];
  assign tx_di   = tx_bit_q - 4'd1;

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_byte_d   = tx_byte_q;
    rx_active_d = rx_active_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_byte_d   = rx_byte_q;
    rx_nbytes_d = rx_nbytes_q;
    res_sr_d    = res_sr_q;
    tcnt_d      = tcnt_q;
    result_d    = result_q;
    tx_line     = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          job_d     = {bus.origin, bus.objetive};
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          tx_byte_d = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (tx_bit_q == 4'd0)      tx_line = 1'b0;
        else if (tx_bit_q == 4'd9) tx_line = 1'b1;
        else                       tx_line = tx_cur[tx_di[2:0]];
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d  = '0;
            job_d     = {job_q[55:0], 8'h00};
            tx_byte_d = tx_byte_q + 3'd1;
            if (tx_byte_q == 3'd7) begin
              state_d     = StRecv;
              rx_active_d = 1'b0;
              rx_nbytes_d = '0;
              tcnt_d      = '0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StRecv: begin
        tcnt_d = tcnt_q + 1'b1;
        if (!rx_active_q) begin
          if (rx_fall) begin
            rx_active_d = 1'b1;
            rx_cnt_d    = '0;
            rx_bit_d    = '0;
            tcnt_d      = '0;
          end
        end else if (rx_bit_q == 4'd0) begin
          // Half-bit re-check of the start bit filters short glitches.
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_d = '0;
            if (rx_s2_q) rx_active_d = 1'b0;
            else         rx_bit_d    = 4'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end else if (rx_cnt_q == BitLast) begin
          rx_cnt_d = '0;
          if (rx_bit_q == 4'd9) begin
            rx_active_d = 1'b0;
            if (!rx_s2_q) begin
              state_d = StAbort;
            end else begin
              res_sr_d    = {res_sr_q[47:0], rx_byte_q};
              rx_nbytes_d = rx_nbytes_q + 3'd1;
              if (rx_nbytes_q == 3'd7) begin
                result_d = {res_sr_q, rx_byte_q};
                state_d  = StDone;
              end
            end
          end else begin
            rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
            rx_bit_d  = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
        if (!(!rx_active_q && rx_fall) && tcnt_q == TimeLast) state_d = StAbort;
      end
      StDone:  state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.tx               = tx_line;
  assign bus.busy             = (state_q == StSend) || (state_q == StRecv);
  assign bus.resultValid      = (state_q == StDone);
  assign bus.timeout          = (state_q == StAbort);
  assign bus.resultError      = result_q[63:48];
  assign bus.resultCounter    = result_q[47:32];
  assign bus.resultIndividual = result_q[31:0];
endmodule

// File: tb/tb_ga_serial_job_master.sv
// Directed bench for ga_serial_job_master: job framing on tx, result collection on rx,
// timeout/framing aborts, glitch rejection and reset during transmission.
module tb_ga_serial_job_master;
  localparam int unsigned Cpb = 8;
  localparam int unsigned To  = 300;
  localparam int unsigned Tw  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ga_serial_job_master_if bus();

  ga_serial_job_master #(
    .ClkPerBit(Cpb),
    .TimeoutCycles(To),
    .TimeoutWidth(Tw)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] origin;
    logic [31:0] objetive;
    logic [63:0] exp_job;
    logic [63:0] reply;
    int          nbytes;
    bit          bad_stop;
    bit          exp_valid;
    logic [63:0] exp_result;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int to_cnt = 0;
  int valid_cyc = 0;
  int to_cyc = 0;
  int last_start_cyc = 0;
  logic busy_at_valid = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.resultValid === 1'b1) begin
      valid_cnt     <= valid_cnt + 1;
      valid_cyc     <= cyc;
      busy_at_valid <= bus.busy;
    end
    if (bus.timeout === 1'b1) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] result_now();
    return {bus.resultError, bus.resultCounter, bus.resultIndividual};
  endfunction

  // Issue start and check every tx cycle against the expected 8N1 stream.
  task automatic send_job(input logic [63:0] exp_job);
    logic [7:0] got;
    logic       bad;
    logic       busy_bad;
    logic       expb;
    bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.origin   = ~bus.origin;
    bus.objetive = ~bus.objetive;
    busy_bad     = 1'b0;
    for (int b = 0; b < 8; b++) begin
      got = '0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < Cpb; c++) begin
          if (i == 0)      expb = 1'b0;
          else if (i == 9) expb = 1'b1;
          else             expb = exp_job[55 - 8 * b + i];
          if (bus.tx !== expb) bad = 1'b1;
          if (c == Cpb / 2 && i >= 1 && i <= 8) got[i-1] = bus.tx;
          if (bus.busy !== 1'b1) busy_bad = 1'b1;
          bus.start = (b == 2 && i == 4 && c == 0);
          tick();
        end
      end
      bus.start = 1'b0;
      check("tx_byte", {56'd0, got}, {56'd0, exp_job[63 - 8 * b -: 8]});
      check("tx_bit_timing", {63'd0, bad}, 64'd0);
    end
    check("busy_during_send", {63'd0, busy_bad}, 64'd0);
    check("busy_in_recv", {63'd0, bus.busy}, 64'd1);
    check("tx_idle_in_recv", {63'd0, bus.tx}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    last_start_cyc = cyc;
    bus.rx = 1'b0;
    repeat (Cpb) tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (Cpb) tick();
    end
    bus.rx = stop;
    repeat (Cpb) tick();
    bus.rx = 1'b1;
  endtask

  task automatic wait_outcome(input int vb, input int tb0);
    int k;
    k = 0;
    while (k < int'(To) + 100 && valid_cnt == vb && to_cnt == tb0) begin
      tick();
      k++;
    end
    check("outcome_seen", {63'd0, (valid_cnt != vb) || (to_cnt != tb0)}, 64'd1);
    repeat (4) tick();
  endtask

  task automatic run_vec(input vec_t v);
    int vb;
    int tb0;
    vb  = valid_cnt;
    tb0 = to_cnt;
    bus.origin   = v.origin;
    bus.objetive = v.objetive;
    send_job(v.exp_job);
    for (int i = 0; i < v.nbytes; i++)
      send_byte(v.reply[63 - 8 * i -: 8], !(v.bad_stop && i == v.nbytes - 1));
    wait_outcome(vb, tb0);
    check("valid_pulses", 64'(valid_cnt - vb), v.exp_valid ? 64'd1 : 64'd0);
    check("timeout_pulses", 64'(to_cnt - tb0), v.exp_valid ? 64'd0 : 64'd1);
    check("result_fields", result_now(), v.exp_result);
    check("busy_after", {63'd0, bus.busy}, 64'd0);
    if (v.exp_valid) begin
      check("busy_low_with_valid", {63'd0, busy_at_valid}, 64'd0);
      check("done_latency", {63'd0, (valid_cyc - last_start_cyc) <= 10 * Cpb + 4}, 64'd1);
    end else if (v.bad_stop) begin
      check("frame_abort_latency", {63'd0, (to_cyc - last_start_cyc) <= 10 * Cpb + 4}, 64'd1);
    end else begin
      check("timeout_latency", {63'd0, (to_cyc - last_start_cyc) >= int'(To) &&
                                       (to_cyc - last_start_cyc) <= int'(To) + 4}, 64'd1);
    end
  endtask

  vec_t vecs[4];
  vec_t glitch_v;

  initial begin
    vecs[0] = '{32'h0010_3810, 32'h387C_3810, 64'h0010_3810_387C_3810,
                64'h0000_012C_A55A_0FF0, 8, 1'b0, 1'b1, 64'h0000_012C_A55A_0FF0};
    vecs[1] = '{32'hDEAD_BEEF, 32'h0123_4567, 64'hDEAD_BEEF_0123_4567,
                64'h1111_2222_3333_4444, 5, 1'b0, 1'b0, 64'h0000_012C_A55A_0FF0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 64'hFFFF_FFFF_0000_0000,
                64'h0102_0304_0506_0708, 3, 1'b1, 1'b0, 64'h0000_012C_A55A_0FF0};
    vecs[3] = '{32'h8000_0001, 32'h7FFF_FFFE, 64'h8000_0001_7FFF_FFFE,
                64'hFEDC_BA98_7654_3210, 8, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210};
    glitch_v = '{32'h1234_5678, 32'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
                 64'h0123_4567_89AB_CDEF, 8, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF};

    // Reset held with rx low: idle outputs, no pulses, no false start.
    rst          = 1'b1;
    bus.rx       = 1'b0;
    bus.start    = 1'b0;
    bus.origin   = '0;
    bus.objetive = '0;
    repeat (3) tick();
    check("rst_tx", {63'd0, bus.tx}, 64'd1);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_result", result_now(), 64'd0);
    rst = 1'b0;
    repeat (6) tick();
    check("post_rst_pulses", 64'(valid_cnt + to_cnt), 64'd0);
    check("post_rst_busy", {63'd0, bus.busy}, 64'd0);
    bus.rx = 1'b1;
    repeat (3) tick();

    for (int n = 0; n < 4; n++) run_vec(vecs[n]);

    // One-cycle rx glitch right after SEND must not become a byte.
    begin
      int vb;
      int tb0;
      vb  = valid_cnt;
      tb0 = to_cnt;
      bus.origin   = glitch_v.origin;
      bus.objetive = glitch_v.objetive;
      send_job(glitch_v.exp_job);
      bus.rx = 1'b0;
      tick();
      bus.rx = 1'b1;
      repeat (20) tick();
      for (int i = 0; i < 8; i++) send_byte(glitch_v.reply[63 - 8 * i -: 8], 1'b1);
      wait_outcome(vb, tb0);
      check("glitch_valid", 64'(valid_cnt - vb), 64'd1);
      check("glitch_no_timeout", 64'(to_cnt - tb0), 64'd0);
      check("glitch_result", result_now(), glitch_v.exp_result);
    end

    // Reset during the fourth job byte, then a full job again.
    bus.origin   = 32'hCAFE_F00D;
    bus.objetive = 32'h5555_AAAA;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3 * 10 * Cpb + 5) tick();
    check("mid_send_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", {63'd0, bus.tx}, 64'd1);
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_rst_result", result_now(), 64'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
